// File: rtl/addr_lookup_arbiter_pkg.sv
// Shared types for the address-lookup arbiter: FSM states and the latched command.
// Combinational definitions only; no latency and no backpressure.
package addr_lookup_pkg;

  localparam int ADDR_WID_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_e;

endpackage

// File: rtl/addr_lookup_arbiter_if.sv
// Requester, segregator and cache-done signals of the lookup arbiter.
// Pure wiring; the master side drives requests and lookup_done, the slave side is the arbiter.
interface addr_lookup_if
  import addr_lookup_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int NUM_REQ  = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_rd;
  logic [NUM_REQ-1:0]          req_wr;
  logic [NUM_REQ*ADDR_WID-1:0] req_addr;
  logic [NUM_REQ-1:0]          req_ack;
  logic                        cmd_rd;
  logic                        cmd_wr;
  logic [ADDR_WID-1:0]         address;
  logic                        lookup_done;
  logic [IDX_W-1:0]            grant_id;
  logic                        busy;
  logic                        lookup_err;

  modport master (
    output req_rd, req_wr, req_addr, lookup_done,
    input  req_ack, cmd_rd, cmd_wr, address, grant_id, busy, lookup_err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, lookup_done,
    output req_ack, cmd_rd, cmd_wr, address, grant_id, busy, lookup_err
  );

endinterface

// File: rtl/addr_lookup_arbiter_rr_pick.sv
// Round-robin picker: first pending index at or after rr_ptr, wrapping upward.
// Purely combinational, zero latency; no backpressure.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W:0] slot;

  assign any_valid = |pending;

  // Walk offsets from farthest to nearest so the closest pending slot is written last.
  always_comb begin
    winner = '0;
    slot   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (slot >= (IDX_W+1)'(NUM_REQ)) begin
        slot = slot - (IDX_W+1)'(NUM_REQ);
      end
      if (pending[slot[IDX_W-1:0]]) begin
        winner = slot[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/addr_lookup_arbiter.sv
// Round-robin owner of the segregator/tag-lookup path; holds cmd until lookup_done, then a 1-cycle ack.
// Grant 1 cycle after request, ack the cycle after lookup_done; optional BUSY timeout via ADDR_LOOKUP_TIMEOUT_EN.
module addr_lookup_arbiter
  import addr_lookup_pkg::*;
#(
  parameter int ADDR_WID       = ADDR_WID_DEF,
  parameter int NUM_REQ        = 4,
  parameter int LOOKUP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  addr_lookup_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state;
  state_e               state_n;
  cmd_e                 cmd_q;
  logic [ADDR_WID-1:0]  address_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   pending;
  logic [IDX_W-1:0]     winner;
  logic                 any_valid;
  logic                 timeout;
  logic [ADDR_WID-1:0]  addr_arr [NUM_REQ];

  assign pending = bus.req_rd | bus.req_wr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = bus.req_addr[i*ADDR_WID +: ADDR_WID];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

`ifdef ADDR_LOOKUP_TIMEOUT_EN
  localparam int TO_W = $clog2(LOOKUP_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            lookup_err_q;

  // lookup_done arriving on the limit cycle takes priority over the timeout.
  assign timeout = (state == ST_BUSY) && !bus.lookup_done &&
                   (to_cnt == TO_W'(LOOKUP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt       <= '0;
      lookup_err_q <= 1'b0;
    end else begin
      lookup_err_q <= timeout;
      if (state == ST_BUSY) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign bus.lookup_err = lookup_err_q;
`else
  assign timeout        = 1'b0;
  assign bus.lookup_err = (LOOKUP_TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (any_valid) state_n = ST_BUSY;
      ST_BUSY: if (bus.lookup_done || timeout) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= CMD_NONE;
      address_q  <= '0;
      grant_id_q <= '0;
      rr_ptr     <= '0;
      req_ack_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      req_ack_q <= '0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id_q <= winner;
            address_q  <= addr_arr[winner];
            cmd_q      <= bus.req_wr[winner] ? CMD_WR : CMD_RD;
            busy_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.lookup_done || timeout) begin
            cmd_q                 <= CMD_NONE;
            req_ack_q[grant_id_q] <= 1'b1;
            rr_ptr <= (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          end
        end
        ST_DONE: busy_q <= 1'b0;
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign bus.cmd_rd   = (cmd_q == CMD_RD);
  assign bus.cmd_wr   = (cmd_q == CMD_WR);
  assign bus.address  = address_q;
  assign bus.grant_id = grant_id_q;
  assign bus.req_ack  = req_ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_addr_lookup_arbiter.sv
// Self-checking bench for addr_lookup_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model.
module tb_addr_lookup_arbiter;

  localparam int AW = 32;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ptr = 0;

  addr_lookup_if #(.ADDR_WID(AW), .NUM_REQ(N)) bus ();

  addr_lookup_arbiter #(
    .ADDR_WID       (AW),
    .NUM_REQ        (N),
    .LOOKUP_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [AW-1:0] a);
    bus.req_rd[i] = rd;
    bus.req_wr[i] = wr;
    bus.req_addr[i*AW +: AW] = a;
  endtask

  function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req_rd = '0; bus.req_wr = '0; bus.req_addr = '0; bus.lookup_done = 1'b0;
    set_req(3, 1'b1, 1'b0, 32'hDEAD_BEEF);
    repeat (3) tick();
    n_cmp++; if (bus.cmd_rd !== 1'b0) begin n_err++; $display("FAIL reset_cmd_rd: got %b expected 0", bus.cmd_rd); end
    n_cmp++; if (bus.cmd_wr !== 1'b0) begin n_err++; $display("FAIL reset_cmd_wr: got %b expected 0", bus.cmd_wr); end
    n_cmp++; if (bus.address !== '0) begin n_err++; $display("FAIL reset_address: got %h expected 0", bus.address); end
    n_cmp++; if (bus.grant_id !== '0) begin n_err++; $display("FAIL reset_grant_id: got %0d expected 0", bus.grant_id); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.req_ack !== '0) begin n_err++; $display("FAIL reset_req_ack: got %b expected 0", bus.req_ack); end
    n_cmp++; if (bus.lookup_err !== 1'b0) begin n_err++; $display("FAIL reset_lookup_err: got %b expected 0", bus.lookup_err); end
    set_req(3, 1'b0, 1'b0, '0);
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single_read();
    set_req(1, 1'b1, 1'b0, 32'hFFFF_0000);
    tick();
    n_cmp++; if (bus.grant_id !== 2'd1) begin n_err++; $display("FAIL read_grant_id: got %0d expected 1", bus.grant_id); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL read_busy: got %b expected 1", bus.busy); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({bus.cmd_rd, bus.cmd_wr} !== 2'b10) begin n_err++; $display("FAIL read_cmd_c%0d: got rd/wr %b expected 10", c, {bus.cmd_rd, bus.cmd_wr}); end
      n_cmp++; if (bus.address !== 32'hFFFF_0000) begin n_err++; $display("FAIL read_addr_c%0d: got %h expected ffff0000", c, bus.address); end
      n_cmp++; if (bus.req_ack !== 4'b0000) begin n_err++; $display("FAIL read_early_ack_c%0d: got %b expected 0000", c, bus.req_ack); end
      if (c == 2) bus.lookup_done = 1'b1;
      tick();
    end
    bus.lookup_done = 1'b0;
    n_cmp++; if (bus.req_ack !== 4'b0010) begin n_err++; $display("FAIL read_ack: got %b expected 0010", bus.req_ack); end
    n_cmp++; if ({bus.cmd_rd, bus.cmd_wr} !== 2'b00) begin n_err++; $display("FAIL read_done_cmd: got %b expected 00", {bus.cmd_rd, bus.cmd_wr}); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL read_done_busy: got %b expected 1", bus.busy); end
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    n_cmp++; if ({bus.busy, bus.req_ack} !== 5'b0_0000) begin n_err++; $display("FAIL read_idle: got busy/ack %b expected 00000", {bus.busy, bus.req_ack}); end
    exp_ptr = 2;
  endtask

  task automatic test_rd_wr();
    set_req(0, 1'b1, 1'b1, 32'hABCD_DCBA);
    tick();
    n_cmp++; if ({bus.cmd_rd, bus.cmd_wr} !== 2'b01) begin n_err++; $display("FAIL rdwr_cmd: got rd/wr %b expected 01", {bus.cmd_rd, bus.cmd_wr}); end
    n_cmp++; if (bus.address !== 32'hABCD_DCBA) begin n_err++; $display("FAIL rdwr_addr: got %h expected abcddcba", bus.address); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL rdwr_grant: got %0d expected 0", bus.grant_id); end
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if (bus.req_ack !== 4'b0001) begin n_err++; $display("FAIL rdwr_ack: got %b expected 0001", bus.req_ack); end
    set_req(0, 1'b0, 1'b0, '0);
    tick();
    exp_ptr = 1;
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < N; i++) set_req(i, (i % 2) == 0, (i % 2) == 1, 32'h1000_0000 + i);
    for (int g = 0; g < 5; g++) begin
      int e;
      logic [N-1:0] ea;
      e = g % N;
      ea = '0; ea[e] = 1'b1;
      tick();
      n_cmp++; if (bus.grant_id !== e[1:0]) begin n_err++; $display("FAIL rr_grant_%0d: got %0d expected %0d", g, bus.grant_id, e); end
      n_cmp++; if (bus.address !== 32'h1000_0000 + e) begin n_err++; $display("FAIL rr_addr_%0d: got %h expected %h", g, bus.address, 32'h1000_0000 + e); end
      n_cmp++; if (bus.cmd_wr !== ((e % 2) == 1)) begin n_err++; $display("FAIL rr_cmd_%0d: got wr %b expected %b", g, bus.cmd_wr, (e % 2) == 1); end
      bus.lookup_done = 1'b1;
      tick();
      bus.lookup_done = 1'b0;
      n_cmp++; if (bus.req_ack !== ea) begin n_err++; $display("FAIL rr_ack_%0d: got %b expected %b", g, bus.req_ack, ea); end
      n_cmp++; if ({bus.cmd_rd, bus.cmd_wr} !== 2'b00) begin n_err++; $display("FAIL rr_done_cmd_%0d: got %b expected 00", g, {bus.cmd_rd, bus.cmd_wr}); end
      tick();
      n_cmp++; if (bus.req_ack !== '0) begin n_err++; $display("FAIL rr_ack_len_%0d: got %b expected 0000", g, bus.req_ack); end
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0);
    exp_ptr = 1;
  endtask

  task automatic test_reset_mid_busy();
    set_req(2, 1'b1, 1'b0, 32'h2222_2222);
    tick();
    n_cmp++; if ({bus.cmd_rd, bus.grant_id} !== 3'b1_10) begin n_err++; $display("FAIL midrst_pre: got rd/grant %b expected 110", {bus.cmd_rd, bus.grant_id}); end
    set_req(0, 1'b1, 1'b0, 32'h0000_0A0A);
    rst = 1'b1;
    tick();
    n_cmp++; if ({bus.cmd_rd, bus.cmd_wr, bus.busy, bus.lookup_err} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctl: got rd/wr/busy/err %b expected 0000", {bus.cmd_rd, bus.cmd_wr, bus.busy, bus.lookup_err}); end
    n_cmp++; if ({bus.address, bus.grant_id} !== '0) begin n_err++; $display("FAIL midrst_data: got addr %h grant %0d expected 0", bus.address, bus.grant_id); end
    n_cmp++; if (bus.req_ack !== '0) begin n_err++; $display("FAIL midrst_ack: got %b expected 0000", bus.req_ack); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_err++; $display("FAIL midrst_next_grant: got %0d expected 0", bus.grant_id); end
    n_cmp++; if (bus.address !== 32'h0000_0A0A) begin n_err++; $display("FAIL midrst_next_addr: got %h expected 00000a0a", bus.address); end
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if (bus.req_ack !== 4'b0001) begin n_err++; $display("FAIL midrst_ack0: got %b expected 0001", bus.req_ack); end
    set_req(0, 1'b0, 1'b0, '0);
    tick();
    tick();
    n_cmp++; if (bus.grant_id !== 2'd2) begin n_err++; $display("FAIL midrst_grant2: got %0d expected 2", bus.grant_id); end
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if (bus.req_ack !== 4'b0100) begin n_err++; $display("FAIL midrst_ack2: got %b expected 0100", bus.req_ack); end
    set_req(2, 1'b0, 1'b0, '0);
    tick();
    exp_ptr = 3;
  endtask

  task automatic test_stray_done();
    bus.lookup_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({bus.busy, bus.req_ack, bus.cmd_rd, bus.cmd_wr} !== 7'b0) begin n_err++; $display("FAIL stray_idle_%0d: got busy/ack/rd/wr %b expected 0", c, {bus.busy, bus.req_ack, bus.cmd_rd, bus.cmd_wr}); end
    end
    bus.lookup_done = 1'b0;
    set_req(3, 1'b0, 1'b1, 32'h3333_0003);
    tick();
    tick();
    n_cmp++; if ({bus.busy, bus.cmd_wr, bus.grant_id, bus.req_ack} !== {1'b1, 1'b1, 2'd3, 4'b0}) begin n_err++; $display("FAIL stray_busy_hold: got %b expected 11110000", {bus.busy, bus.cmd_wr, bus.grant_id, bus.req_ack}); end
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if (bus.req_ack !== 4'b1000) begin n_err++; $display("FAIL stray_ack: got %b expected 1000", bus.req_ack); end
    set_req(3, 1'b0, 1'b0, '0);
    tick();
    exp_ptr = 0;
  endtask

  task automatic test_timeout();
    set_req(1, 1'b1, 1'b0, 32'h5555_AAAA);
    tick();
`ifdef ADDR_LOOKUP_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      n_cmp++; if ({bus.busy, bus.req_ack, bus.lookup_err} !== 6'b1_0000_0) begin n_err++; $display("FAIL to_wait_c%0d: got busy/ack/err %b expected 100000", c, {bus.busy, bus.req_ack, bus.lookup_err}); end
      if (c < TO) tick();
    end
    tick();
    n_cmp++; if ({bus.req_ack, bus.lookup_err} !== 5'b0010_1) begin n_err++; $display("FAIL to_pulse: got ack/err %b expected 00101", {bus.req_ack, bus.lookup_err}); end
    n_cmp++; if ({bus.cmd_rd, bus.cmd_wr} !== 2'b00) begin n_err++; $display("FAIL to_cmd: got %b expected 00", {bus.cmd_rd, bus.cmd_wr}); end
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    n_cmp++; if ({bus.req_ack, bus.lookup_err} !== 5'b0) begin n_err++; $display("FAIL to_err_len: got ack/err %b expected 00000", {bus.req_ack, bus.lookup_err}); end
    set_req(2, 1'b1, 1'b0, 32'h6666_0006);
    tick();
    repeat (TO - 1) tick();
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if ({bus.req_ack, bus.lookup_err} !== 5'b0100_0) begin n_err++; $display("FAIL to_tie: got ack/err %b expected 01000", {bus.req_ack, bus.lookup_err}); end
    set_req(2, 1'b0, 1'b0, '0);
    tick();
    exp_ptr = 3;
`else
    for (int c = 0; c < 100; c++) begin
      n_cmp++; if ({bus.busy, bus.req_ack, bus.lookup_err} !== 6'b1_0000_0) begin n_err++; $display("FAIL nto_wait_c%0d: got busy/ack/err %b expected 100000", c, {bus.busy, bus.req_ack, bus.lookup_err}); end
      tick();
    end
    bus.lookup_done = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    n_cmp++; if ({bus.req_ack, bus.lookup_err} !== 5'b0010_0) begin n_err++; $display("FAIL nto_ack: got ack/err %b expected 00100", {bus.req_ack, bus.lookup_err}); end
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    exp_ptr = 2;
`endif
  endtask

  task automatic test_random();
    logic [N-1:0]  pend;
    logic [N-1:0]  is_wr;
    logic [AW-1:0] a [N];
    pend = '0; is_wr = '0;
    for (int i = 0; i < N; i++) a[i] = '0;
    for (int it = 0; it < 150; it++) begin
      int w;
      int len;
      logic [N-1:0] ea;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 2);
          pend[i] = 1'b1;
          is_wr[i] = (kind != 0);
          a[i] = $urandom;
          set_req(i, kind != 1, kind != 0, a[i]);
        end
      end
      bus.lookup_done = ($urandom_range(0, 3) == 0);
      tick();
      bus.lookup_done = 1'b0;
      w = model_pick(pend, exp_ptr);
      if (w < 0) begin
        n_cmp++; if ({bus.busy, bus.req_ack} !== 5'b0) begin n_err++; $display("FAIL rnd_idle_%0d: got busy/ack %b expected 00000", it, {bus.busy, bus.req_ack}); end
        continue;
      end
      n_cmp++; if (bus.grant_id !== w[1:0]) begin n_err++; $display("FAIL rnd_grant_%0d: got %0d expected %0d", it, bus.grant_id, w); end
      len = $urandom_range(1, 4);
      for (int c = 1; c <= len; c++) begin
        n_cmp++; if (bus.address !== a[w]) begin n_err++; $display("FAIL rnd_addr_%0d_c%0d: got %h expected %h", it, c, bus.address, a[w]); end
        n_cmp++; if ({bus.busy, bus.cmd_rd, bus.cmd_wr} !== {1'b1, !is_wr[w], is_wr[w]}) begin n_err++; $display("FAIL rnd_cmd_%0d_c%0d: got busy/rd/wr %b expected %b", it, c, {bus.busy, bus.cmd_rd, bus.cmd_wr}, {1'b1, !is_wr[w], is_wr[w]}); end
        if (c == len) bus.lookup_done = 1'b1;
        tick();
      end
      bus.lookup_done = 1'b0;
      ea = '0; ea[w] = 1'b1;
      n_cmp++; if ({bus.req_ack, bus.cmd_rd, bus.cmd_wr, bus.busy, bus.lookup_err} !== {ea, 4'b0010}) begin n_err++; $display("FAIL rnd_done_%0d: got ack/rd/wr/busy/err %b expected %b", it, {bus.req_ack, bus.cmd_rd, bus.cmd_wr, bus.busy, bus.lookup_err}, {ea, 4'b0010}); end
      pend[w] = 1'b0;
      set_req(w, 1'b0, 1'b0, '0);
      exp_ptr = (w + 1) % N;
      tick();
      n_cmp++; if ({bus.busy, bus.req_ack} !== 5'b0) begin n_err++; $display("FAIL rnd_back_idle_%0d: got busy/ack %b expected 00000", it, {bus.busy, bus.req_ack}); end
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rd_wr();
    test_round_robin();
    test_reset_mid_busy();
    test_stray_done();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected the run to finish");
    $fatal(1);
  end

endmodule
